// File: rtl/pc_npc_unit.sv
// pc_npc_unit: SPARC-style PC/nPC pair with a single delayed-control-transfer
// slot. A two-state FSM (NORMAL, DELAY) tracks whether pc_out addresses the
// delay-slot instruction of a taken branch. All outputs are registered.
// trap redirects to trap_vector from either state. Reset is synchronous and
// active-high, and it overrides trap, le and branch_taken.
//
// Optional feature: define PC_NPC_ALIGN_CHECK_EN to reject taken-branch
// targets whose low two bits are non-zero. A rejected branch becomes a
// sequential advance and pulses misalign. Without the macro, targets load
// unmodified and misalign is tied to 0.
module pc_npc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] RESET_NPC = WIDTH'(4),
  parameter logic [WIDTH-1:0] INC       = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             le,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             annul,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_vector,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] npc_out,
  output logic             in_delay_slot,
  output logic             squash,
  output logic             dcti_err,
  output logic             misalign
);

  // DELAY means the instruction now at pc_out sits in a branch delay slot.
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DELAY  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_npc;
  logic             r_squash;
  logic             r_dcti_err;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_npc_nxt;
  logic             w_squash_nxt;
  logic             w_dcti_err_nxt;
  logic [WIDTH-1:0] w_seq_npc;
  logic [WIDTH-1:0] w_trap_npc;
  logic             w_target_bad;

  // Both sums wrap modulo 2^WIDTH because the result keeps only WIDTH bits.
  assign w_seq_npc  = r_npc + INC;
  assign w_trap_npc = trap_vector + INC;

`ifdef PC_NPC_ALIGN_CHECK_EN
  logic r_misalign;
  logic w_misalign_nxt;

  // A word-aligned target has zero in its two lowest bits.
  assign w_target_bad = |branch_target[1:0];
`else
  // With the alignment check compiled out, every target is accepted.
  assign w_target_bad = 1'b0;
`endif

  // Next-state and next-output decode. Trap wins over le; le=0 holds state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_npc_nxt      = r_npc;
    w_squash_nxt   = r_squash;
    w_dcti_err_nxt = 1'b0;
`ifdef PC_NPC_ALIGN_CHECK_EN
    w_misalign_nxt = 1'b0;
`endif

    if (trap) begin
      w_state_nxt  = ST_NORMAL;
      w_pc_nxt     = trap_vector;
      w_npc_nxt    = w_trap_npc;
      w_squash_nxt = 1'b0;
    end else if (le) begin
      // Every advance moves nPC into PC. The sequential case is the default.
      w_state_nxt  = ST_NORMAL;
      w_pc_nxt     = r_npc;
      w_npc_nxt    = w_seq_npc;
      w_squash_nxt = 1'b0;

      unique case (r_state)
        ST_NORMAL: begin
          if (branch_taken) begin
            if (w_target_bad) begin
`ifdef PC_NPC_ALIGN_CHECK_EN
              w_misalign_nxt = 1'b1;
`endif
            end else begin
              w_state_nxt  = ST_DELAY;
              w_npc_nxt    = branch_target;
              w_squash_nxt = annul;
            end
          end
        end
        ST_DELAY: begin
          // A control transfer inside a delay slot is refused. The delay
          // slot retires sequentially and the refusal is flagged.
          w_dcti_err_nxt = branch_taken;
        end
      endcase
    end
  end

  // FSM state register; reset overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge and the result does not depend on
    // the order in which blocks are evaluated.
    if (reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC/nPC and flag registers; they load the decoded next values each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_npc      <= RESET_NPC;
      r_squash   <= 1'b0;
      r_dcti_err <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_npc      <= w_npc_nxt;
      r_squash   <= w_squash_nxt;
      r_dcti_err <= w_dcti_err_nxt;
    end
  end

`ifdef PC_NPC_ALIGN_CHECK_EN
  // Registered one-cycle pulse for a rejected misaligned branch target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_nxt;
    end
  end

  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  assign pc_out        = r_pc;
  assign npc_out       = r_npc;
  assign in_delay_slot = (r_state == ST_DELAY);
  assign squash        = r_squash;
  assign dcti_err      = r_dcti_err;

endmodule
